// File: rtl/sub_flag_stage_if.sv
// -----------------------------------------------------------------------------
// sub_flag_stage_if
// Handshake/data bundle for the subtract flag stage.
//   in_valid/in_ready          : upstream handshake
//   in_a, in_b, in_diff        : operands and raw subtractor result
//   out_valid/out_ready        : downstream handshake
//   out_res, out_z/n/c/v       : head result and its flags
// Modports:
//   slave  - the stage itself (consumes upstream, produces downstream)
//   master - the environment driving the stage
// -----------------------------------------------------------------------------
interface sub_flag_stage_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_diff;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_z;
   logic             out_n;
   logic             out_c;
   logic             out_v;

   modport slave (
      input  in_valid, in_a, in_b, in_diff, out_ready,
      output in_ready, out_valid, out_res, out_z, out_n, out_c, out_v
   );

   modport master (
      output in_valid, in_a, in_b, in_diff, out_ready,
      input  in_ready, out_valid, out_res, out_z, out_n, out_c, out_v
   );
endinterface

// File: rtl/sub_flag_stage.sv
// -----------------------------------------------------------------------------
// sub_flag_stage
// Takes the operands and raw result of an 8-bit subtractor, computes the
// zero/negative/borrow/overflow flags at acceptance, and buffers entries in a
// 2-entry skid buffer (EMPTY/ONE/TWO) with strict FIFO order. Records the flags
// of the last delivered entry and counts deliveries.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : sub_flag_stage_if.slave (handshakes, operands, head outputs)
//   flag_clr    : synchronous clear of flags_q (wins over a same-cycle load)
//   flags_q     : {v,c,n,z} of the last delivered entry
//   op_cnt      : number of output transfers, wraps at 256
//
// Build option:
//   SUB_SAT_EN  : when defined, the result saturates to 0 on borrow
//                 (Z and N follow the saturated value, C and V do not change).
// -----------------------------------------------------------------------------
module sub_flag_stage #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sub_flag_stage_if.slave       bus,
   input  logic                  flag_clr,
   output logic [3:0]            flags_q,
   output logic [7:0]            op_cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             v;
      logic             c;
      logic             n;
      logic             z;
   } entry_t;

   state_t state, nxt;
   logic   rdy_q;
   logic   ov;
   logic   in_xfer, out_xfer;
   entry_t head, skid, new_ent;

   assign in_xfer  = bus.in_valid && rdy_q;
   assign out_xfer = ov && bus.out_ready;

   // Flags for the incoming entry, evaluated on the raw operands.
   always_comb begin
      new_ent   = '0;
      new_ent.c = (bus.in_a < bus.in_b);
      new_ent.v = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                  (bus.in_diff[WIDTH-1] != bus.in_a[WIDTH-1]);
`ifdef SUB_SAT_EN
      new_ent.res = new_ent.c ? '0 : bus.in_diff;
`else
      new_ent.res = bus.in_diff;
`endif
      new_ent.n = new_ent.res[WIDTH-1];
      new_ent.z = (new_ent.res == '0);
   end

   // State register; in_ready is a flop so it never depends on in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= nxt;
         rdy_q <= (nxt != TWO);
      end
   end

   // Next state
   always_comb begin
      nxt = state;
      case (state)
         EMPTY: if (in_xfer) nxt = ONE;
         ONE: begin
            if (in_xfer && !out_xfer)      nxt = TWO;
            else if (!in_xfer && out_xfer) nxt = EMPTY;
         end
         TWO:     if (out_xfer) nxt = ONE;
         default: nxt = EMPTY;
      endcase
   end

   // Outputs: purely from registered state
   always_comb begin
      ov            = (state != EMPTY);
      bus.out_valid = ov;
      bus.in_ready  = rdy_q;
      bus.out_res   = head.res;
      bus.out_z     = head.z;
      bus.out_n     = head.n;
      bus.out_c     = head.c;
      bus.out_v     = head.v;
   end

   // Entry storage. Head only changes on acceptance into an empty head slot,
   // on a pass-through in ONE, or on promotion from skid, so it is stable
   // while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         skid <= '0;
      end else begin
         case (state)
            EMPTY: if (in_xfer) head <= new_ent;
            ONE: begin
               if (in_xfer && out_xfer) head <= new_ent;
               else if (in_xfer)        skid <= new_ent;
            end
            TWO:     if (out_xfer) head <= skid;
            default: ;
         endcase
      end
   end

   // Status and transfer counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
         op_cnt  <= '0;
      end else begin
         if (flag_clr)      flags_q <= '0;
         else if (out_xfer) flags_q <= {head.v, head.c, head.n, head.z};
         if (out_xfer)      op_cnt  <= op_cnt + 8'd1;
      end
   end

endmodule
